// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline constants and fetch state encoding
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // All-zero word decodes to the Reset control word.
    localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_FETCH,
        FS_WAIT,
        FS_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response interface
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry instruction/PC holding register
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        fill,
    input  logic        drain,
    input  logic [31:0] fill_instr,
    input  logic [31:0] fill_pc,
    output logic        buf_valid,
    output logic [31:0] buf_instr,
    output logic [31:0] buf_pc
);

    // Clear wins over fill, fill wins over drain so a refill in a drain cycle keeps the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_instr <= 32'h0;
            buf_pc    <= 32'h0;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (fill) begin
            buf_valid <= 1'b1;
            buf_instr <= fill_instr;
            buf_pc    <= fill_pc;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with IF/ID register
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    input  logic         stall_d,
    input  logic         flush_d,
    input  logic         pc_src_e,
    input  logic [31:0]  pc_target_e,
    output logic [31:0]  instr_d,
    output logic [31:0]  pc_d,
    output logic [31:0]  pc_plus4_d,
    output logic         valid_d
);

    fetch_state_t fs, fs_next;
    logic [31:0]  pc_f, req_pc;
    logic         buf_valid;
    logic [31:0]  buf_instr, buf_pc;
    logic         rsp_take, if_load, buf_fill, buf_drain, req_valid, hs;

    // A response counts only in WAIT and only when no redirect discards it.
    assign rsp_take  = imem.imem_rsp_valid && (fs == FS_WAIT) && !pc_src_e;
    assign if_load   = !flush_d && !stall_d;
    assign buf_fill  = rsp_take && (!if_load || buf_valid);
    assign buf_drain = buf_valid && if_load;
    assign hs        = req_valid && imem.imem_req_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_f;

    // State register for the fetch FSM.
    always_ff @(posedge clk) begin
        if (reset) fs <= FS_FETCH;
        else       fs <= fs_next;
    end

    // Next-state and request issue; a response about to be buffered also blocks
    // issue so a second response can never arrive while the buffer is full.
    always_comb begin
        fs_next   = fs;
        req_valid = !pc_src_e && !buf_valid && !buf_fill &&
                    ((fs == FS_FETCH) || ((fs == FS_WAIT) && imem.imem_rsp_valid));
        if (pc_src_e) begin
            if (fs == FS_WAIT)
                fs_next = imem.imem_rsp_valid ? FS_FETCH : FS_DROP;
            else if ((fs == FS_DROP) && imem.imem_rsp_valid)
                fs_next = FS_FETCH;
        end else if (hs) begin
            fs_next = FS_WAIT;
        end else if ((fs != FS_FETCH) && imem.imem_rsp_valid) begin
            fs_next = FS_FETCH;
        end
    end

    // Fetch PC and the PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f   <= RESET_PC;
            req_pc <= 32'h0;
        end else if (pc_src_e) begin
            pc_f <= pc_target_e;
        end else if (hs) begin
            req_pc <= pc_f;
            pc_f   <= pc_f + 32'd4;
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .reset      (reset),
        .clear      (pc_src_e),
        .fill       (buf_fill),
        .drain      (buf_drain),
        .fill_instr (imem.imem_rsp_data),
        .fill_pc    (req_pc),
        .buf_valid  (buf_valid),
        .buf_instr  (buf_instr),
        .buf_pc     (buf_pc)
    );

    // IF/ID register: flush, then stall, then oldest available instruction, else bubble.
    always_ff @(posedge clk) begin
        if (reset || flush_d) begin
            instr_d    <= INSTR_BUBBLE;
            pc_d       <= 32'h0;
            pc_plus4_d <= 32'h0;
            valid_d    <= 1'b0;
        end else if (!stall_d) begin
            if (buf_valid) begin
                instr_d    <= buf_instr;
                pc_d       <= buf_pc;
                pc_plus4_d <= buf_pc + 32'd4;
                valid_d    <= 1'b1;
            end else if (rsp_take) begin
                instr_d    <= imem.imem_rsp_data;
                pc_d       <= req_pc;
                pc_plus4_d <= req_pc + 32'd4;
                valid_d    <= 1'b1;
            end else begin
                instr_d    <= INSTR_BUBBLE;
                pc_d       <= 32'h0;
                pc_plus4_d <= 32'h0;
                valid_d    <= 1'b0;
            end
        end
    end

endmodule
